// File: rtl/sparse_output_encoder.sv
// Drain stage: ReLU + shift quantisation + saturation, then zero-run-length
// encoding of each tile into (value, index) pairs written to sequential OARAM addresses.
module sparse_output_encoder #(
   parameter int ACC_WIDTH   = 25,
   parameter int VALUE_WIDTH = 8,
   parameter int INDEX_WIDTH = 4,
   parameter int RAM_WIDTH   = 10
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        start,
   input  logic [4:0]                  shift,
   input  logic                        in_valid,
   output logic                        in_ready,
   input  logic signed [ACC_WIDTH-1:0] in_data,
   input  logic                        in_last,
   output logic [VALUE_WIDTH-1:0]      oaram_value,
   output logic [INDEX_WIDTH-1:0]      oaram_index,
   output logic [RAM_WIDTH-1:0]        oaram_address,
   output logic                        oaram_write_enable,
   output logic                        done,
   output logic                        overflow,
   output logic [RAM_WIDTH:0]          entry_count,
   output logic [1:0]                  dbg_state
);

   // Handshake: a beat transfers on a rising edge where in_valid && in_ready;
   // in_ready is high only in RUN and there is no backpressure from the OARAM side.
   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_RUN    = 2'd1,
      S_FINISH = 2'd2
   } state_t;

   localparam logic [ACC_WIDTH-1:0]   MAXVAL    = {{(ACC_WIDTH-VALUE_WIDTH){1'b0}}, {VALUE_WIDTH{1'b1}}};
   localparam logic [INDEX_WIDTH-1:0] MAXRUN    = '1;
   localparam logic [RAM_WIDTH-1:0]   LAST_ADDR = '1;

   state_t                   r_state;
   state_t                   w_next;
   logic [4:0]               r_shift;
   logic [INDEX_WIDTH-1:0]   r_zr;
   logic [RAM_WIDTH-1:0]     r_addr;
   logic [RAM_WIDTH-1:0]     r_wr_addr;
   logic [RAM_WIDTH:0]       r_count;
   logic                     r_overflow;
   logic                     r_we;
   logic [VALUE_WIDTH-1:0]   r_value;
   logic [INDEX_WIDTH-1:0]   r_index;
   logic                     w_accept;
   logic [ACC_WIDTH-1:0]     w_shifted;
   logic [VALUE_WIDTH-1:0]   w_q;
   logic                     w_emit;

   assign w_accept  = in_valid && (r_state == S_RUN);
   assign w_shifted = $unsigned(in_data) >> r_shift;

   always_comb begin
      w_q = '0;
      if (in_data[ACC_WIDTH-1]) begin
         w_q = '0;
      end else if (w_shifted > MAXVAL) begin
         w_q = '1;
      end else begin
         w_q = w_shifted[VALUE_WIDTH-1:0];
      end
   end

   // A full run of MAXRUN zeros plus this zero is flushed as a (0, MAXRUN) entry.
   assign w_emit = (w_q != '0) || (r_zr == MAXRUN);

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:   if (start) w_next = S_RUN;
         S_RUN:    if (w_accept && in_last) w_next = S_FINISH;
         S_FINISH: w_next = S_IDLE;
         default:  w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_shift    <= '0;
         r_zr       <= '0;
         r_addr     <= '0;
         r_wr_addr  <= '0;
         r_count    <= '0;
         r_overflow <= 1'b0;
         r_we       <= 1'b0;
         r_value    <= '0;
         r_index    <= '0;
      end else begin
         r_we <= 1'b0;
         if ((r_state == S_IDLE) && start) begin
            r_shift    <= shift;
            r_zr       <= '0;
            r_addr     <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
         end
         if (r_state == S_FINISH) begin
            r_zr <= '0;
         end
         if (w_accept) begin
            if (w_emit) begin
               r_zr      <= '0;
               r_value   <= w_q;
               r_index   <= r_zr;
               r_wr_addr <= r_addr;
               // The last address is still written; afterwards the address holds and writes drop.
               if (!r_overflow) begin
                  r_we    <= 1'b1;
                  r_count <= r_count + 1'b1;
                  if (r_addr == LAST_ADDR) begin
                     r_overflow <= 1'b1;
                  end else begin
                     r_addr <= r_addr + 1'b1;
                  end
               end
            end else begin
               r_zr <= r_zr + 1'b1;
            end
         end
      end
   end

   assign in_ready           = (r_state == S_RUN);
   assign done               = (r_state == S_FINISH);
   assign oaram_write_enable = r_we;
   assign oaram_value        = r_value;
   assign oaram_index        = r_index;
   assign oaram_address      = r_we ? r_wr_addr : r_addr;
   assign overflow           = r_overflow;
   assign entry_count        = r_count;
   assign dbg_state          = r_state;

endmodule

// File: tb/tb_sparse_output_encoder.sv
// Bench for sparse_output_encoder: table-driven tiles with a write scoreboard, plus
// hand-written overflow, bubble/start-ignore and mid-tile reset sequences.
module tb_sparse_output_encoder;

   typedef struct {
      logic [4:0] shift;
      int         b_lo;
      int         b_n;
      int         e_lo;
      int         e_n;
      int         cnt;
   } vec_t;

   logic               clk = 1'b0;
   logic               reset = 1'b1;
   logic               start = 1'b0;
   logic [4:0]         shift = '0;
   logic               in_valid = 1'b0;
   logic signed [24:0] in_data = '0;
   logic               in_last = 1'b0;

   logic               in_ready, s_in_ready;
   logic [7:0]         o_value, s_value;
   logic [3:0]         o_index, s_index;
   logic [9:0]         o_address;
   logic [1:0]         s_address;
   logic               o_we, s_we;
   logic               o_done, s_done;
   logic               o_overflow, s_overflow;
   logic [10:0]        o_count;
   logic [2:0]         s_count;
   logic [1:0]         o_state, s_state;

   logic [21:0]        exp_q[$];
   logic [21:0]        exp_s_q[$];
   logic signed [24:0] bq[$];
   logic [21:0]        eq[$];
   vec_t               vecs[$];
   vec_t               cur;
   bit                 chk_small = 1'b0;
   int                 n_cmp = 0;
   int                 n_fail = 0;

   always #5 clk = ~clk;

   sparse_output_encoder u_dut (
      .clk(clk), .reset(reset), .start(start), .shift(shift),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
      .oaram_value(o_value), .oaram_index(o_index), .oaram_address(o_address),
      .oaram_write_enable(o_we), .done(o_done), .overflow(o_overflow),
      .entry_count(o_count), .dbg_state(o_state)
   );

   sparse_output_encoder #(.RAM_WIDTH(2)) u_small (
      .clk(clk), .reset(reset), .start(start), .shift(shift),
      .in_valid(in_valid), .in_ready(s_in_ready), .in_data(in_data), .in_last(in_last),
      .oaram_value(s_value), .oaram_index(s_index), .oaram_address(s_address),
      .oaram_write_enable(s_we), .done(s_done), .overflow(s_overflow),
      .entry_count(s_count), .dbg_state(s_state)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic add_b(input int d);
      bq.push_back(25'(d));
   endtask

   task automatic add_e(input int v, input int i, input int a);
      eq.push_back({8'(v), 4'(i), 10'(a)});
   endtask

   task automatic begin_vec(input int s);
      cur.shift = 5'(s);
      cur.b_lo  = bq.size();
      cur.e_lo  = eq.size();
   endtask

   task automatic end_vec(input int cnt);
      cur.b_n = bq.size() - cur.b_lo;
      cur.e_n = eq.size() - cur.e_lo;
      cur.cnt = cnt;
      vecs.push_back(cur);
   endtask

   task automatic drive_start(input logic [4:0] s);
      shift = s;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      check("ready_after_start", 32'(in_ready), 32'd1);
   endtask

   task automatic drive_beat(input logic signed [24:0] d, input logic l);
      int n;
      in_valid = 1'b1;
      in_data  = d;
      in_last  = l;
      n = 0;
      while (!in_ready && n < 8) begin
         @(posedge clk); #1;
         n++;
      end
      if (!in_ready) check("beat_ready_timeout", 32'(in_ready), 32'd1);
      @(posedge clk); #1;
      in_valid = 1'b0;
      in_last  = 1'b0;
      in_data  = '0;
   endtask

   task automatic check_reset_vals();
      check("rst_in_ready", 32'(in_ready), 32'd0);
      check("rst_we", 32'(o_we), 32'd0);
      check("rst_done", 32'(o_done), 32'd0);
      check("rst_overflow", 32'(o_overflow), 32'd0);
      check("rst_value", 32'(o_value), 32'd0);
      check("rst_index", 32'(o_index), 32'd0);
      check("rst_address", 32'(o_address), 32'd0);
      check("rst_count", 32'(o_count), 32'd0);
      check("rst_state", 32'(o_state), 32'd0);
   endtask

   task automatic run_vec(input int k, input bit bubbles);
      vec_t v;
      bit   pulsed;
      v = vecs[k];
      pulsed = 1'b0;
      for (int e = 0; e < v.e_n; e++) exp_q.push_back(eq[v.e_lo + e]);
      drive_start(v.shift);
      for (int j = 0; j < v.b_n; j++) begin
         if (bubbles && j > 0 && $urandom_range(0, 1) == 1) begin
            for (int g = 0; g < int'($urandom_range(1, 2)); g++) begin
               if (!pulsed) begin
                  start = 1'b1;
                  shift = 5'd7;
                  pulsed = 1'b1;
               end
               @(posedge clk); #1;
               start = 1'b0;
               shift = v.shift;
            end
         end
         drive_beat(bq[v.b_lo + j], j == v.b_n - 1);
      end
      check($sformatf("v%0d_done", k), 32'(o_done), 32'd1);
      check($sformatf("v%0d_ready_finish", k), 32'(in_ready), 32'd0);
      check($sformatf("v%0d_count", k), 32'(o_count), 32'(v.cnt));
      @(posedge clk); #1;
      check($sformatf("v%0d_done_low", k), 32'(o_done), 32'd0);
      check($sformatf("v%0d_ready_idle", k), 32'(in_ready), 32'd0);
      check($sformatf("v%0d_next_addr", k), 32'(o_address), 32'(v.cnt));
      check($sformatf("v%0d_writes_left", k), 32'(exp_q.size()), 32'd0);
   endtask

   task automatic monitor();
      logic [21:0] got;
      forever begin
         @(negedge clk);
         if (o_we) begin
            got = {o_value, o_index, o_address};
            if (exp_q.size() == 0) check("wr_unexpected", 32'(got), 32'h3fffff);
            else check("wr_pair", 32'(got), 32'(exp_q.pop_front()));
         end
         if (chk_small && s_we) begin
            got = {s_value, s_index, 8'd0, s_address};
            if (exp_s_q.size() == 0) check("small_wr_unexpected", 32'(got), 32'h3fffff);
            else check("small_wr_pair", 32'(got), 32'(exp_s_q.pop_front()));
         end
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      // T0 basic encode
      begin_vec(0);
      add_b(5); add_b(0); add_b(0); add_b(7); add_b(-3); add_b(0); add_b(9);
      add_e(5, 0, 0); add_e(7, 2, 1); add_e(9, 2, 2);
      end_vec(3);
      // T1 quantise / saturate, trailing zeros dropped
      begin_vec(4);
      add_b(4095); add_b(16); add_b(15); add_b(-1000);
      add_e(255, 0, 0); add_e(1, 0, 1);
      end_vec(2);
      // T2 largest positive input saturates; shifted-to-zero tail dropped
      begin_vec(2);
      add_b(16777215); add_b(0); add_b(-5); add_b(1023); add_b(3);
      add_e(255, 0, 0); add_e(255, 2, 1);
      end_vec(2);
      // T3 long zero run
      begin_vec(0);
      for (int i = 0; i < 20; i++) add_b(0);
      add_b(3);
      add_e(0, 15, 0); add_e(3, 4, 1);
      end_vec(2);
      // T4 six nonzero beats (overflows the 4-entry instance)
      begin_vec(0);
      for (int i = 1; i <= 6; i++) begin
         add_b(i);
         add_e(i, 0, i - 1);
      end
      end_vec(6);

      fork
         monitor();
      join_none

      repeat (3) @(posedge clk);
      #1;
      check_reset_vals();
      reset = 1'b0;
      @(posedge clk); #1;

      for (int k = 0; k < 4; k++) run_vec(k, 1'b0);

      chk_small = 1'b1;
      for (int i = 1; i <= 4; i++) exp_s_q.push_back({8'(i), 4'd0, 10'(i - 1)});
      run_vec(4, 1'b0);
      check("small_overflow", 32'(s_overflow), 32'd1);
      check("small_count", 32'(s_count), 32'd4);
      check("small_addr_hold", 32'(s_address), 32'd3);
      check("small_writes_left", 32'(exp_s_q.size()), 32'd0);
      check("big_no_overflow", 32'(o_overflow), 32'd0);
      chk_small = 1'b0;

      run_vec(0, 1'b1);
      check("small_overflow_cleared", 32'(s_overflow), 32'd0);
      check("small_count_new_tile", 32'(s_count), 32'd3);

      exp_q.push_back({8'd5, 4'd0, 10'd0});
      exp_q.push_back({8'd7, 4'd0, 10'd1});
      drive_start(5'd0);
      drive_beat(25'sd5, 1'b0);
      drive_beat(25'sd7, 1'b0);
      drive_beat(25'sd0, 1'b0);
      reset = 1'b1;
      @(posedge clk); #1;
      check_reset_vals();
      reset = 1'b0;
      check("midreset_writes_left", 32'(exp_q.size()), 32'd0);
      @(posedge clk); #1;
      run_vec(0, 1'b0);

      repeat (2) @(posedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
